// File: rtl/nmos_demux_strobe.sv
// nmos_demux_strobe: registered 1-of-2**SEL_W strobe demultiplexer.
// A request in IDLE launches a one-hot strobe on B that lasts exactly
// PULSE_LEN clocks. An internal pointer supplies the index in auto mode,
// advancing (modulo N_OUT) at the end of each auto strobe, with a
// one-cycle WRAP pulse on the N_OUT-1 -> 0 transition.
module nmos_demux_strobe #(
    parameter int SEL_W     = 3,
    parameter int PULSE_LEN = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  A,
    input  logic [SEL_W-1:0]      S,
    input  logic                  AUTO,
    input  logic                  LOAD,
    output logic [2**SEL_W-1:0]   B,
    output logic                  BUSY,
    output logic [SEL_W-1:0]      PTR,
    output logic                  WRAP
);

    localparam int N_OUT = 2 ** SEL_W;
    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               auto_q, auto_d;
    logic [N_OUT-1:0]   b_q, b_d;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               wrap_q, wrap_d;
    logic [SEL_W-1:0]   idx_sel;
    logic               ptr_inc;

    // Strobe index chosen at request time: pointer (or the value being
    // loaded into it this edge) in auto mode, otherwise the explicit select.
    assign idx_sel = AUTO ? (LOAD ? S : ptr_q) : S;

    // Next-state logic for the strobe sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;
        b_d     = b_q;
        busy_d  = busy_q;
        ptr_inc = 1'b0;

        case (state_q)
            IDLE: begin
                b_d    = '0;
                busy_d = 1'b0;
                if (A) begin
                    b_d     = N_OUT'(1) << idx_sel;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(PULSE_LEN - 1);
                    auto_d  = AUTO;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                // Strobe held; new requests are dropped, not queued.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    b_d     = '0;
                    busy_d  = 1'b0;
                    ptr_inc = auto_q;
                    state_d = IDLE;
                end
            end
            default: begin
                b_d     = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Pointer update: a load always beats a coincident increment, and only
    // an increment out of the top index raises WRAP.
    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        if (LOAD) begin
            ptr_d = S;
        end else if (ptr_inc) begin
            ptr_d  = ptr_q + SEL_W'(1);
            wrap_d = (ptr_q == SEL_W'(N_OUT - 1));
        end
    end

    // State and output registers; reset clears the strobe without a clock.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            auto_q  <= 1'b0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign B    = b_q;
    assign BUSY = busy_q;
    assign PTR  = ptr_q;
    assign WRAP = wrap_q;

endmodule

// File: doc/nmos_demux_strobe.md
Name: nmos_demux_strobe

Overview:
Parametrised, registered successor to the combinational 1-of-8 NMOS demultiplexer. It decodes a SEL_W-bit select into a one-hot strobe on 2**SEL_W outputs. Each request produces a strobe lasting exactly PULSE_LEN clocks. An internal pointer supports auto-increment scanning with wrap-around, as used for row/column strobe sequencing in the NMOS library models.

Parameters:
SEL_W, 3, select width; number of outputs N_OUT = 2**SEL_W (derived, not overridable)
PULSE_LEN, 1, strobe width in clocks; legal range 1..255; counter width = clog2(PULSE_LEN+1)

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
A  input  1  strobe request, sampled only in IDLE
S  input  SEL_W  explicit select index / pointer load value
AUTO  input  1  1 = strobe index comes from internal pointer; 0 = from S
LOAD  input  1  load pointer from S
B  output  N_OUT  registered one-hot strobe bus, B[i] corresponds to index i
BUSY  output  1  1 while a strobe is being driven
PTR  output  SEL_W  current pointer value
WRAP  output  1  one-cycle pulse when the pointer wraps N_OUT-1 -> 0

Behaviour:
- Interface: one clock CLK; reset RST_N is asynchronous and active-low.
- Reset (async assert, sync-to-CLK release): B=0, BUSY=0, PTR=0, WRAP=0, state IDLE, counter 0. Reset mid-strobe clears B on RST_N fall, with no clock edge required.
- States: IDLE, PULSE. No other states; any illegal encoding returns to IDLE.
- IDLE, A=1 at edge:
  - Capture idx = AUTO ? (LOAD ? S : PTR) : S.
  - Next cycle: B = 1<<idx, BUSY=1, cnt = PULSE_LEN-1, go to PULSE. Latency request-edge -> B high is one clock.
  - Record AUTO as auto_cap.
- IDLE, A=0: B=0, BUSY=0.
- PULSE:
  - B holds constant; S, AUTO and A are ignored (A is dropped, not queued).
  - If cnt!=0: cnt-1.
  - If cnt==0: B=0, BUSY=0, go to IDLE. If auto_cap=1, PTR increments at this edge.
  - B is therefore high for exactly PULSE_LEN cycles. Minimum request period is PULSE_LEN+1 cycles.
- Pointer:
  - LOAD=1 at any edge, in any state: PTR <= S. LOAD wins over a coincident increment.
  - Increment is modulo N_OUT. When PTR goes N_OUT-1 -> 0 by increment (not by LOAD), WRAP=1 for the following cycle only.
  - Explicit mode (AUTO=0) never changes PTR except through LOAD.
  - LOAD during PULSE does not alter the B currently driven.
- Outputs: B has at most one bit set in any cycle. B is all-zero whenever BUSY=0. B, BUSY and WRAP are all registered, with no combinational path from inputs.
- PULSE_LEN=1: PULSE lasts one cycle. Back-to-back requests give alternating strobe/idle cycles.

Test Plan:
1. SEL_W=3, PULSE_LEN=1, AUTO=0: A=1 for one edge with S=5 -> next cycle B=8'b00100000, BUSY=1; the cycle after, B=0, BUSY=0; PTR stays 0.
2. PULSE_LEN=3, AUTO=0, S=2, A held high for 10 cycles -> B=8'h04 for 3 cycles, 0 for 1 cycle, repeating. Changing S mid-pulse does not alter B.
3. AUTO=1, PULSE_LEN=1: after reset issue 9 requests -> strobes on B[0],B[1],...,B[7],B[0]. PTR returns to 0 after the 8th strobe, with WRAP=1 for exactly one cycle then.
4. AUTO=1: LOAD=1, S=6 together with A=1 in IDLE -> strobe on B[6], PTR ends at 7. LOAD=1, S=3 on the increment edge -> PTR=3, WRAP=0.
5. PULSE_LEN=4: mid-strobe (cycle 2) drop RST_N asynchronously between edges -> B=0, BUSY=0, PTR=0 immediately. After release, A=1 with S=1 -> B=8'h02 for a full 4 cycles.
6. SEL_W=4, PULSE_LEN=2, random A/S/AUTO/LOAD for 10k cycles vs. reference model -> B is one-hot or zero every cycle, never set while BUSY=0, and the strobe width is always 2.
